mem_port_arbiter: RTL

// - Round-robin arbiter/sequencer for one shared memory port with 4 requesters (e.g. IF, MEM, DMA, debug).
// - Drives the 2-bit select of the 4:1 address/wdata mux in front of the port.
// - Owns the port transaction: issues mem_valid, waits for mem_ready, returns a one-hot completion.
// - Aborts a transaction that exceeds a wait limit and flags the error.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for a single shared memory port with four requesters.
// Owns the port transaction: grant, wait for ready (with timeout abort), one-hot completion.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ready,
    output logic [3:0] done,
    output logic       err,
    output logic       err_sticky,
    output logic       busy
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               mem_valid_q, mem_valid_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic               err_sticky_q, err_sticky_d;

    logic [N_REQ-1:0]   elig;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;

    // Rotating-priority pick; a requester is masked in the cycle it sees its done
    always_comb begin
        elig      = req & ~done_q;
        cand      = '0;
        win_idx   = last_q;
        win_found = 1'b0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = last_q + IDX_W'(i);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        mem_valid_d  = mem_valid_q;
        done_d       = '0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = BUSY;
                    cnt_d       = '0;
                    gnt_d       = N_REQ'(1) << win_idx;
                    sel_d       = win_idx;
                    mem_valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    mem_valid_d = 1'b0;
                    done_d      = gnt_q;
                    last_d      = sel_q;
                end else if (cnt_q == WAIT_LAST) begin
                    // this edge completes the MAX_WAIT-th cycle without ready
                    state_d      = IDLE;
                    gnt_d        = '0;
                    mem_valid_d  = 1'b0;
                    err_d        = 1'b1;
                    err_sticky_d = 1'b1;
                    last_d       = sel_q;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= IDX_W'(N_REQ - 1);
            gnt_q        <= '0;
            sel_q        <= '0;
            mem_valid_q  <= 1'b0;
            done_q       <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            mem_valid_q  <= mem_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign mem_valid  = mem_valid_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign busy       = (state_q == BUSY);

endmodule
